approx_div_32by16: RTL and testbench
====================================

# approx_div_32by16

Sequential restoring divider that undoes the 16x16 approximate multiplier: it divides a 32-bit product-width dividend by a 16-bit divisor and returns a 16-bit quotient and 16-bit remainder. It is the inverse-direction companion of the approximate multiplier tree and is used in the same power-efficient datapath. Accuracy is traded for latency and switching activity by skipping the last `APPROX_BITS` iterations. Datapath registers are enabled only while a division is being accepted or computed, so they hold and do not toggle in idle.

## Interface
- `APPROX_BITS`, default 0: number of least-significant quotient bits not computed, forced to 0. Legal range 0..8.
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  request valid.
- `in_ready`  output  1  high only in IDLE.
- `dividend`  input  32  dividend, sampled on accept.
- `divisor`  input  16  divisor, sampled on accept.
- `out_valid`  output  1  result valid; high only in DONE.
- `out_ready`  input  1  consumer accepts the result.
- `quotient`  output  16  registered quotient.
- `remainder`  output  16  registered remainder.
- `div_by_zero`  output  1  divisor was 0.
- `overflow`  output  1  quotient does not fit in 16 bits: `dividend[31:16] >= divisor`, divisor nonzero.

## Operation
- States: IDLE, BUSY, DONE. Reset forces IDLE.
- IDLE: `in_ready`=1. Accept when `in_valid & in_ready` at a rising edge.
  - `divisor==0`: go to DONE. `quotient`=16'hFFFF, `remainder`=0, `div_by_zero`=1, `overflow`=0.
  - Else if `dividend[31:16] >= divisor`: go to DONE. `quotient`=16'hFFFF, `remainder`=0, `overflow`=1.
  - Otherwise: load R (17 bits) with `{1'b0, dividend[31:16]}`, Q with `dividend[15:0]`, D with `divisor`, clear the iteration counter, and go to BUSY.
- BUSY: one restoring step per cycle, N = 16 − `APPROX_BITS` steps total.
  - Form T = `{R[15:0], Q[15]}`.
  - If T ≥ D: R = T − D and the quotient bit is 1. Else R = T and the quotient bit is 0.
  - Update Q = `{Q[14:0], qbit}`.
  - Because R < D holds throughout, R never exceeds 16 significant bits.
- After step N, go to DONE.
  - `quotient` = `{Q[N-1:0], APPROX_BITS'b0}`.
  - `remainder` = R[15:0] when `APPROX_BITS`==0; otherwise `remainder` is forced to 0.
  - Both flags are 0.
- DONE: `out_valid`=1. Outputs and flags are held stable until `out_ready`=1 at an edge, then the block returns to IDLE.
- There is no overlap: a new request cannot be accepted in the same cycle as the result handshake.
- Clock-enable rule: the R, Q, D and counter registers load only on accept or in BUSY. Output registers load only on the transition into DONE.

## Timing
- Reset values: `in_ready`=1 once `rst_n` is high; `out_valid`=0; `quotient`=0; `remainder`=0; `div_by_zero`=0; `overflow`=0; state=IDLE.
- Accept edge at the end of cycle 0:
  - Normal case: BUSY in cycles 1..N, `out_valid` high from cycle N+1. Latency is 17 cycles for `APPROX_BITS`=0 and 13 cycles for `APPROX_BITS`=4.
  - Zero-divisor and overflow cases: `out_valid` high in cycle 1.
- `out_ready` held high in DONE: `out_valid` is high for exactly 1 cycle, and `in_ready` rises in the next cycle.
- Minimum issue interval: N+2 cycles for normal divisions, 2 cycles for zero-divisor and overflow cases.
- Reset asserted in any state, including mid-BUSY or DONE with `out_ready` low: immediate return to IDLE with the reset values above, and the in-flight result is discarded.
- `in_valid` while not in IDLE is ignored; the input is not sampled.

## Test plan
- `dividend`=32'h0001_2345, `divisor`=16'h0010, `APPROX_BITS`=0 -> `quotient`=16'h1234, `remainder`=16'h0005, flags 0, `out_valid` first high 17 cycles after accept.
- `dividend`=32'hFFFE_0001, `divisor`=16'hFFFF -> `quotient`=16'hFFFF, `remainder`=0, no overflow. `dividend`=32'h0000_0007, `divisor`=16'h0003 -> `quotient`=2, `remainder`=1.
- `divisor`=0 with any dividend -> `div_by_zero`=1, `quotient`=16'hFFFF, `remainder`=0, `out_valid` 1 cycle after accept. `dividend`=32'h0010_0000, `divisor`=16'h0010 -> `overflow`=1, same output values.
- `APPROX_BITS`=4, `dividend`=32'h0001_2345, `divisor`=16'h0010 -> `quotient`=16'h1230, `remainder`=0, latency 13 cycles.
- `out_ready` held low for 5 cycles in DONE -> outputs stable, `in_ready`=0, a new `in_valid` is ignored. Then raise `out_ready` -> IDLE one cycle later.
- Assert `rst_n` low at BUSY step 8 -> all outputs go to their reset values immediately. After release, a new request (32'h0000_0064 / 16'h0007) -> `quotient`=14, `remainder`=2.

Source files
------------

// File: rtl/approx_div_32by16.sv
// Sequential restoring 32/16 divider; the last APPROX_BITS quotient bits are
// skipped to save latency and switching, and come out as zero.
module approx_div_32by16 #(
  parameter int APPROX_BITS = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        div_by_zero,
  output logic        overflow
);

  localparam int         STEPS = 16 - APPROX_BITS;
  localparam logic [3:0] LAST  = 4'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    logic        ov;
  } result_t;

  state_t      state, state_nxt;
  logic [15:0] r_q, q_q, d_q;
  logic [3:0]  cnt;
  result_t     res, res_nxt;

  logic        accept, step_en, last_step, early, dz_in, ov_in;
  logic [16:0] t;
  logic        qbit;
  logic [15:0] r_nxt, q_nxt;

  // Requests that cannot yield a 16-bit quotient short-circuit straight to DONE.
  assign dz_in = (divisor == 16'd0);
  assign ov_in = !dz_in && (dividend[31:16] >= divisor);
  assign early = dz_in | ov_in;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)   state_nxt = early ? DONE : BUSY;
      BUSY:    if (cnt == LAST) state_nxt = DONE;
      DONE:    if (out_ready)  state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    accept    = in_ready & in_valid;
    step_en   = (state == BUSY);
    last_step = step_en & (cnt == LAST);
  end

  // ---------------- restoring step ----------------
  // R < D is invariant, so the 17-bit partial remainder fits in 16 bits of state.
  always_comb begin
    t     = {r_q, q_q[15]};
    qbit  = (t >= {1'b0, d_q});
    r_nxt = qbit ? 16'(t - {1'b0, d_q}) : t[15:0];
    q_nxt = {q_q[14:0], qbit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
      q_q <= '0;
      d_q <= '0;
      cnt <= '0;
    end else if (accept && !early) begin
      r_q <= dividend[31:16];
      q_q <= dividend[15:0];
      d_q <= divisor;
      cnt <= '0;
    end else if (step_en) begin
      r_q <= r_nxt;
      q_q <= q_nxt;
      cnt <= cnt + 4'd1;
    end
  end

  // ---------------- result registers ----------------
  // The skipped low bits are zero; the partial remainder is meaningless then.
  always_comb begin
    res_nxt = '0;
    if (state == IDLE) begin
      res_nxt.q  = 16'hFFFF;
      res_nxt.dz = dz_in;
      res_nxt.ov = ov_in;
    end else begin
      res_nxt.q = 16'(q_nxt << APPROX_BITS);
      res_nxt.r = (APPROX_BITS == 0) ? r_nxt : 16'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           res <= '0;
    else if ((accept && early) || last_step) res <= res_nxt;
  end

  assign quotient    = res.q;
  assign remainder   = res.r;
  assign div_by_zero = res.dz;
  assign overflow    = res.ov;

endmodule

// File: tb/tb_approx_div_32by16.sv
// Drives an exact (APPROX_BITS=0) and an approximate (APPROX_BITS=4) divider in
// lockstep and checks both against an arithmetic reference.
module tb_approx_div_32by16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] dividend = '0;
  logic [15:0] divisor = '0;

  logic        in_ready0, out_valid0, dz0, ov0;
  logic [15:0] quot0, rem0;
  logic        in_ready4, out_valid4, dz4, ov4;
  logic [15:0] quot4, rem4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  approx_div_32by16 #(.APPROX_BITS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid0),
    .out_ready(out_ready), .quotient(quot0), .remainder(rem0),
    .div_by_zero(dz0), .overflow(ov0)
  );

  approx_div_32by16 #(.APPROX_BITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid4),
    .out_ready(out_ready), .quotient(quot4), .remainder(rem4),
    .div_by_zero(dz4), .overflow(ov4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, then drop the low approx quotient bits.
  task automatic model(input int a, input logic [31:0] dvd, input logic [15:0] dvs,
                       output logic [15:0] q, output logic [15:0] r,
                       output logic dz, output logic ov, output int lat);
    longint unsigned qq, rr;
    dz = (dvs == 0);
    ov = !dz && (dvd[31:16] >= dvs);
    if (dz || ov) begin
      q = 16'hFFFF; r = 16'h0; lat = 1;
    end else begin
      qq = longint'(dvd) / longint'(dvs);
      rr = longint'(dvd) % longint'(dvs);
      q  = 16'((qq >> a) << a);
      r  = (a == 0) ? 16'(rr) : 16'h0;
      lat = 16 - a + 1;
    end
  endtask

  task automatic run(input logic [31:0] dvd, input logic [15:0] dvs, input string tag);
    int lat0 = 0, lat4 = 0, hi0 = 0, hi4 = 0;
    logic rdy0 = 1'b0, rdy4 = 1'b0;
    logic [15:0] q0 = '0, r0 = '0, q4 = '0, r4 = '0;
    logic f0d = 1'b0, f0o = 1'b0, f4d = 1'b0, f4o = 1'b0;
    logic [15:0] eq, er;
    logic edz, eov;
    int elat;
    @(negedge clk);
    chk({tag, ".in_ready"}, {30'd0, in_ready0, in_ready4}, 32'd3);
    dividend = dvd; divisor = dvs; out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (lat0 != 0 && c == lat0 + 1) rdy0 = in_ready0;
      if (lat4 != 0 && c == lat4 + 1) rdy4 = in_ready4;
      if (out_valid0) begin
        hi0++;
        if (lat0 == 0) begin lat0 = c; q0 = quot0; r0 = rem0; f0d = dz0; f0o = ov0; end
      end
      if (out_valid4) begin
        hi4++;
        if (lat4 == 0) begin lat4 = c; q4 = quot4; r4 = rem4; f4d = dz4; f4o = ov4; end
      end
      @(posedge clk); #1;
    end
    model(0, dvd, dvs, eq, er, edz, eov, elat);
    chk({tag, ".a0.lat"}, lat0, elat);
    chk({tag, ".a0.pulse"}, hi0, 1);
    chk({tag, ".a0.ready_after"}, {31'd0, rdy0}, 32'd1);
    chk({tag, ".a0.q"}, {16'd0, q0}, {16'd0, eq});
    chk({tag, ".a0.r"}, {16'd0, r0}, {16'd0, er});
    chk({tag, ".a0.flags"}, {30'd0, f0d, f0o}, {30'd0, edz, eov});
    model(4, dvd, dvs, eq, er, edz, eov, elat);
    chk({tag, ".a4.lat"}, lat4, elat);
    chk({tag, ".a4.pulse"}, hi4, 1);
    chk({tag, ".a4.ready_after"}, {31'd0, rdy4}, 32'd1);
    chk({tag, ".a4.q"}, {16'd0, q4}, {16'd0, eq});
    chk({tag, ".a4.r"}, {16'd0, r4}, {16'd0, er});
    chk({tag, ".a4.flags"}, {30'd0, f4d, f4o}, {30'd0, edz, eov});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".out_valid"}, {30'd0, out_valid0, out_valid4}, 32'd0);
    chk({tag, ".q"}, {quot0, quot4}, 32'd0);
    chk({tag, ".r"}, {rem0, rem4}, 32'd0);
    chk({tag, ".flags"}, {28'd0, dz0, ov0, dz4, ov4}, 32'd0);
  endtask

  initial begin
    logic [15:0] dvs;
    logic [15:0] hi;
    int sel;

    #23 chk_reset_outputs("rst_low");
    @(negedge clk) rst_n = 1'b1;
    #1 chk("rst.in_ready", {30'd0, in_ready0, in_ready4}, 32'd3);
    chk_reset_outputs("rst_rel");

    // Directed cases
    run(32'h0001_2345, 16'h0010, "basic");
    run(32'hFFFE_0001, 16'hFFFF, "max");
    run(32'h0000_0007, 16'h0003, "small");
    run(32'h1234_5678, 16'h0000, "divzero");
    run(32'h0010_0000, 16'h0010, "ovf_eq");
    run(32'h000F_FFFF, 16'h0010, "ovf_edge_ok");

    // DONE held with out_ready low; new requests must be ignored
    @(negedge clk);
    dividend = 32'h0001_2345; divisor = 16'h0010; out_ready = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (18) @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      dividend = 32'h0000_0009; divisor = 16'h0002; in_valid = 1'b1;
      #1;
      chk("hold.valid", {30'd0, out_valid0, out_valid4}, 32'd3);
      chk("hold.in_ready", {30'd0, in_ready0, in_ready4}, 32'd0);
      chk("hold.q", {quot0, quot4}, {16'h1234, 16'h1230});
      chk("hold.r", {rem0, rem4}, {16'h0005, 16'h0000});
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release.in_ready", {30'd0, in_ready0, in_ready4}, 32'd3);
    chk("release.out_valid", {30'd0, out_valid0, out_valid4}, 32'd0);
    chk("release.q_held", {quot0, quot4}, {16'h1234, 16'h1230});

    // Reset in the middle of BUSY
    @(negedge clk);
    dividend = 32'h0001_2345; divisor = 16'h0010; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midbusy_rst");
    @(negedge clk) rst_n = 1'b1;
    #1 chk("midbusy_rst.in_ready", {30'd0, in_ready0, in_ready4}, 32'd3);
    run(32'h0000_0064, 16'h0007, "after_rst");

    // Randomized mix of normal, zero-divisor and overflow requests
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        dvs = 16'h0;
        hi  = 16'($urandom);
      end else if (sel == 1) begin
        dvs = 16'($urandom_range(1, 65535));
        hi  = 16'($urandom_range(int'(dvs), 65535));
      end else begin
        dvs = (sel < 4) ? 16'($urandom_range(1, 15)) : 16'($urandom_range(1, 65535));
        hi  = 16'($urandom_range(0, int'(dvs) - 1));
      end
      run({hi, 16'($urandom)}, dvs, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
